// File: rtl/ps2_kbd_rx_if.sv
// Key-event read port of the PS/2 keyboard receiver.
// master = event source (receiver), slave = host logic popping events.
interface ps2_kbd_rx_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          rd_en;
  logic          ev_valid;
  logic [7:0]    ev_code;
  logic          ev_break;
  logic          ev_ext;
  logic [CW-1:0] fifo_count;

  modport master (
    input  rd_en,
    output ev_valid, ev_code, ev_break,
    output ev_ext, fifo_count
  );

  modport slave (
    output rd_en,
    input  ev_valid, ev_code, ev_break,
    input  ev_ext, fifo_count
  );
endinterface

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: filtered edge detect, frame FSM,
// Set-2 E0/F0 prefix decode and a show-ahead key-event FIFO.
module ps2_kbd_rx #(
  parameter int FILT_LEN    = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 50000,
  parameter int REPORT_MAKE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2clk,
  input  logic ps2data,
  ps2_kbd_rx_if.master ev,
  output logic frame_err,
  output logic overflow
);
  localparam int H  = FILT_LEN / 2;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    IDLE, DATA, PARITY, STOP
  } state_t;

  state_t          state;
  logic [FILT_LEN-1:0] hist;
  logic [1:0]      dsync;
  logic            fall;
  logic            din;
  logic [7:0]      sh;
  logic [2:0]      bitcnt;
  logic            par;
  logic            ext;
  logic            brk;
  logic [TW-1:0]   to;
  logic            push;
  logic [9:0]      push_ev;

  logic [9:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wp;
  logic [AW-1:0]   rp;
  logic [CW-1:0]   count;
  logic            empty;
  logic            full;
  logic            do_pop;
  logic            do_push;
  logic [9:0]      head;

  // The history doubles as the ps2clk synchroniser.
  assign fall = (&hist[FILT_LEN-1:H]) & ~(|hist[H-1:0]);
  assign din  = dsync[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist  <= '0;
      dsync <= '0;
    end else begin
      hist  <= {hist[FILT_LEN-2:0], ps2clk};
      dsync <= {dsync[0], ps2data};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      sh        <= '0;
      bitcnt    <= '0;
      par       <= 1'b0;
      ext       <= 1'b0;
      brk       <= 1'b0;
      to        <= '0;
      push      <= 1'b0;
      push_ev   <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      push      <= 1'b0;
      if (state == IDLE || fall)
        to <= '0;
      else
        to <= to + 1'b1;
      if (state != IDLE && !fall &&
          to == TW'(TIMEOUT_CYC - 1)) begin
        frame_err <= 1'b1;
        state     <= IDLE;
        ext       <= 1'b0;
        brk       <= 1'b0;
      end else if (fall) begin
        unique case (state)
          IDLE: begin
            if (!din) begin
              state  <= DATA;
              bitcnt <= '0;
            end else begin
              frame_err <= 1'b1;
              ext       <= 1'b0;
              brk       <= 1'b0;
            end
          end
          DATA: begin
            sh     <= {din, sh[7:1]};
            bitcnt <= bitcnt + 1'b1;
            if (bitcnt == 3'd7)
              state <= PARITY;
          end
          PARITY: begin
            par   <= din;
            state <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (!din || !(^{sh, par})) begin
              frame_err <= 1'b1;
              ext       <= 1'b0;
              brk       <= 1'b0;
            end else if (sh == 8'hE0) begin
              ext <= 1'b1;
            end else if (sh == 8'hF0) begin
              brk <= 1'b1;
            end else begin
              push    <= (REPORT_MAKE != 0) || brk;
              push_ev <= {ext, brk, sh};
              ext     <= 1'b0;
              brk     <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign empty   = (count == '0);
  assign full    = (count == CW'(FIFO_DEPTH));
  assign do_pop  = ev.rd_en & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wp] <= push_ev;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp       <= '0;
      rp       <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= push & full & ~do_pop;
      if (do_push)
        wp <= wp + 1'b1;
      if (do_pop)
        rp <= rp + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head          = mem[rp];
  assign ev.ev_valid   = ~empty;
  assign ev.ev_code    = empty ? 8'h00 : head[7:0];
  assign ev.ev_break   = ~empty & head[8];
  assign ev.ev_ext     = ~empty & head[9];
  assign ev.fifo_count = count;
endmodule
